// File: rtl/simd_pipe_pkg.sv
// SIMD pipeline stage shared definitions.
// State encoding and default geometry for the skid-buffered stage.
package simd_pipe_pkg;

    localparam int DEF_LANES  = 2;
    localparam int DEF_LANE_W = 64;
    localparam int DEF_CTRL_W = 16;
    localparam int STALL_W    = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with clear.
// Holds at all-ones instead of wrapping.
module pipe_sat_cnt
    import simd_pipe_pkg::*;
#(
    parameter int W = STALL_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear wins, increment stops at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/simd_pipe_stage.sv
// Two-entry skid-buffered SIMD pipeline stage.
// Main entry drives outputs; skid absorbs one beat under backpressure.
module simd_pipe_stage
    import simd_pipe_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int LANE_W = DEF_LANE_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*LANE_W-1:0] in_data,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [LANES-1:0]        in_lane_en,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*LANE_W-1:0] out_data,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [LANES-1:0]        out_lane_en,
    output logic [STALL_W-1:0]      stall_cnt
);

    localparam int DW = LANES * LANE_W;

    state_e            state_q, state_d;
    logic [DW-1:0]     main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [LANES-1:0]  main_en_q, main_en_d;
    logic [DW-1:0]     skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [LANES-1:0]  skid_en_q, skid_en_d;

    logic [DW-1:0]     in_gated;
    logic              accept;
    logic              fire;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign fire      = out_valid && out_ready;

    // zero disabled lanes before they are stored
    always_comb begin
        in_gated = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_en[i]) begin
                in_gated[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W];
            end
        end
    end

    // occupancy state machine and entry steering
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        main_en_d   = main_en_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_en_d   = skid_en_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = ONE;
                    main_data_d = in_gated;
                    main_ctrl_d = in_ctrl;
                    main_en_d   = in_lane_en;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    main_data_d = in_gated;
                    main_ctrl_d = in_ctrl;
                    main_en_d   = in_lane_en;
                end else if (accept) begin
                    state_d     = TWO;
                    skid_data_d = in_gated;
                    skid_ctrl_d = in_ctrl;
                    skid_en_d   = in_lane_en;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (fire) begin
                    state_d     = ONE;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    main_en_d   = skid_en_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // state and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            main_en_q   <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_en_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            main_en_q   <= main_en_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_en_q   <= skid_en_d;
        end
    end

    assign out_data    = main_data_q;
    assign out_ctrl    = main_ctrl_q;
    assign out_lane_en = main_en_q;

    pipe_sat_cnt #(.W(STALL_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (out_valid && !out_ready),
        .clr (1'b0),
        .cnt (stall_cnt)
    );

endmodule

// File: tb/tb_simd_pipe_stage.sv
// Bench for simd_pipe_stage: vector table, directed corner sequences,
// and a negedge scoreboard tracking every accepted beat.
module tb_simd_pipe_stage;

    localparam int LANES  = 2;
    localparam int LANE_W = 64;
    localparam int CTRL_W = 16;
    localparam int DW     = LANES * LANE_W;

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [CTRL_W-1:0] ctrl;
        logic [LANES-1:0]  en;
    } beat_t;

    typedef struct {
        logic [LANES-1:0]  en;
        logic [DW-1:0]     data;
        logic [CTRL_W-1:0] ctrl;
        logic [DW-1:0]     exp_data;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [LANES-1:0]  in_lane_en = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DW-1:0]     out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [LANES-1:0]  out_lane_en;
    logic [15:0]       stall_cnt;

    int    n_tests = 0;
    int    n_fail  = 0;
    beat_t sb_q[$];
    beat_t cur_exp = '0;
    beat_t sb_exp;
    logic              hold = 1'b0;
    logic [DW-1:0]     h_data;
    logic [CTRL_W-1:0] h_ctrl;
    logic [LANES-1:0]  h_en;
    vec_t  tbl[6];

    always #5 clk = ~clk;

    simd_pipe_stage #(
        .LANES (LANES),
        .LANE_W(LANE_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_lane_en (in_lane_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_lane_en(out_lane_en),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] gate(input logic [DW-1:0] d,
                                           input logic [LANES-1:0] en);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            if (en[i]) r[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d,
                         input logic [CTRL_W-1:0] c,
                         input logic [LANES-1:0] en,
                         input logic [DW-1:0] expd);
        in_valid   = v;
        in_data    = d;
        in_ctrl    = c;
        in_lane_en = en;
        cur_exp    = {expd, c, en};
    endtask

    task automatic beat(input int c);
        logic [DW-1:0] d;
        d = {64'(c) * 64'h0101_0101_0101_0101, 64'(c) + 64'h5000};
        drive(1'b1, d, 16'(c), 2'b11, d);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // scoreboard and output-stability monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stable_valid", out_valid, 1);
                    chk("stable_data", out_data, h_data);
                    chk("stable_ctrl", out_ctrl, h_ctrl);
                    chk("stable_en", out_lane_en, h_en);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_underflow: got ctrl %0h want no beat", out_ctrl);
                    end else begin
                        sb_exp = sb_q.pop_front();
                        chk("sb_data", out_data, sb_exp.data);
                        chk("sb_ctrl", out_ctrl, sb_exp.ctrl);
                        chk("sb_en", out_lane_en, sb_exp.en);
                    end
                end
                if (flush) sb_q.delete();
                else if (in_valid && in_ready) sb_q.push_back(cur_exp);
                hold   = out_valid && !out_ready && !flush;
                h_data = out_data;
                h_ctrl = out_ctrl;
                h_en   = out_lane_en;
            end
        end
    end

    initial begin
        tbl[0] = '{2'b11, {64'hAAAA_AAAA_AAAA_AAAA, 64'h1234}, 16'h0100,
                   {64'hAAAA_AAAA_AAAA_AAAA, 64'h1234}};
        tbl[1] = '{2'b01, {64'hAAAA_AAAA_AAAA_AAAA, 64'h1234}, 16'h0101,
                   {64'h0, 64'h1234}};
        tbl[2] = '{2'b10, {64'hAAAA_AAAA_AAAA_AAAA, 64'h1234}, 16'h0102,
                   {64'hAAAA_AAAA_AAAA_AAAA, 64'h0}};
        tbl[3] = '{2'b00, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                   16'h0103, {64'h0, 64'h0}};
        tbl[4] = '{2'b11, {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF},
                   16'hBEEF, {64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF}};
        tbl[5] = '{2'b01, {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001},
                   16'hFFFF, {64'h0, 64'h8000_0000_0000_0001}};

        do_reset();
        look();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ctrl", out_ctrl, 0);
        chk("rst_en", out_lane_en, 0);
        tick();

        // four-beat stream, one per cycle
        out_ready = 1'b1;
        beat(1);
        tick();
        for (int i = 2; i <= 5; i++) begin
            if (i <= 4) beat(i);
            else in_valid = 1'b0;
            look();
            chk("stream_valid", out_valid, 1);
            chk("stream_ctrl", out_ctrl, 16'(i - 1));
            tick();
        end
        look();
        chk("stream_done", out_valid, 0);
        tick();

        // vector table with lane gating
        for (int i = 0; i <= 6; i++) begin
            if (i < 6) drive(1'b1, tbl[i].data, tbl[i].ctrl, tbl[i].en, tbl[i].exp_data);
            else in_valid = 1'b0;
            look();
            if (i > 0) begin
                chk("vec_data", out_data, tbl[i-1].exp_data);
                chk("vec_ctrl", out_ctrl, tbl[i-1].ctrl);
                chk("vec_en", out_lane_en, tbl[i-1].en);
            end
            tick();
        end

        // backpressure: three offered, two held
        do_reset();
        beat(10);
        tick();
        beat(11);
        look();
        chk("bp_ready1", in_ready, 1);
        chk("bp_ctrl1", out_ctrl, 10);
        chk("bp_stall0", stall_cnt, 0);
        tick();
        beat(12);
        look();
        chk("bp_ready_two", in_ready, 0);
        chk("bp_stall1", stall_cnt, 1);
        tick();
        look();
        chk("bp_ready_two2", in_ready, 0);
        chk("bp_stall2", stall_cnt, 2);
        chk("bp_ctrl_hold", out_ctrl, 10);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        look();
        chk("bp_stall3", stall_cnt, 3);
        tick();
        look();
        chk("bp_ctrl2", out_ctrl, 11);
        chk("bp_valid2", out_valid, 1);
        chk("bp_stall_keep", stall_cnt, 3);
        tick();
        look();
        chk("bp_drained", out_valid, 0);
        chk("bp_sb_empty", sb_q.size(), 0);
        tick();

        // flush while full with a beat offered
        do_reset();
        beat(20);
        tick();
        beat(21);
        tick();
        beat(22);
        flush = 1'b1;
        look();
        chk("fl_ready_two", in_ready, 0);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        look();
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_stall", stall_cnt, 2);
        tick();
        repeat (3) tick();
        look();
        chk("fl_nobeat", out_valid, 0);
        chk("fl_sb_empty", sb_q.size(), 0);
        tick();

        // reset while full with stall_cnt=5
        do_reset();
        beat(30);
        tick();
        beat(31);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        look();
        chk("rt_stall5", stall_cnt, 5);
        chk("rt_full", in_ready, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        look();
        chk("rt_valid", out_valid, 0);
        chk("rt_ready", in_ready, 1);
        chk("rt_stall", stall_cnt, 0);
        chk("rt_data", out_data, 0);
        chk("rt_ctrl", out_ctrl, 0);
        chk("rt_en", out_lane_en, 0);
        tick();

        // random traffic checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0]    d;
            logic [LANES-1:0] en;
            d  = {$urandom, $urandom, $urandom, $urandom};
            en = LANES'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, d, 16'($urandom), en, gate(d, en));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        look();
        chk("rnd_drained", out_valid, 0);
        chk("rnd_sb_empty", sb_q.size(), 0);
        tick();

        // stall counter saturation
        do_reset();
        beat(40);
        tick();
        in_valid = 1'b0;
        repeat (65534) tick();
        look();
        chk("sat_fffe", stall_cnt, 16'hFFFE);
        tick();
        repeat (5) tick();
        look();
        chk("sat_ffff", stall_cnt, 16'hFFFF);
        chk("sat_ctrl", out_ctrl, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
